// File: rtl/ram_pkg.sv
// Shared constants and types for the simple-dual-port RAM with clear sequencer.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

endpackage

// File: rtl/ram_sdp_core.sv
// Bare simple-dual-port array: one write port, one registered read port, no reset.
// Read-before-write ordering in one process gives old data on same-address collisions.
module ram_sdp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with a hardware clear sweep, selectable read-during-write
// behaviour, optional output register and a read-valid strobe.
module ram_sdp_init
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 14,
  parameter int                OUT_REG  = 0,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] dob,
  output logic              rvalid
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADR = (ADDR_W + 1)'(DEPTH - 1);

  clr_state_t        state;
  logic [ADDR_W:0]   clr_addr;
  logic              clearing;
  logic              wr_a;
  logic              rd_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] core_q;
  logic              rd_v1;
  logic              has_data;
  logic              coll;
  logic [DATA_W-1:0] byp;
  logic [DATA_W-1:0] stage1;

  assign clearing  = (state == ST_CLEAR);
  assign wr_a      = ena & wea & ~clearing & ~rst;
  assign rd_b      = enb & ~clearing & ~rst;
  assign mem_we    = clearing | wr_a;
  assign mem_waddr = clearing ? clr_addr[ADDR_W-1:0] : addra;
  assign mem_wdata = clearing ? INIT_VAL : dia;

  // Clear sweep owns the write port for exactly DEPTH cycles after reset or a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == LAST_ADR) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ram_sdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_b),
    .raddr (addrb),
    .rdata (core_q)
  );

  // Bypass state only moves on a real read, so dob holds across idle slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1    <= 1'b0;
      has_data <= 1'b0;
      coll     <= 1'b0;
      byp      <= '0;
    end else begin
      rd_v1 <= rd_b;
      if (rd_b) begin
        has_data <= 1'b1;
        coll     <= wr_a && (addra == addrb);
        byp      <= dia;
      end
    end
  end

  always_comb begin
    stage1 = core_q;
    if (!has_data) stage1 = '0;
    else if ((RDW_MODE == RDW_WRITE_FIRST) && coll) stage1 = byp;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] dob_r;
      logic              rd_v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          dob_r <= '0;
          rd_v2 <= 1'b0;
        end else begin
          rd_v2 <= rd_v1;
          if (rd_v1) dob_r <= stage1;
        end
      end

      assign dob    = dob_r;
      assign rvalid = rd_v2;
    end else begin : g_noreg
      assign dob    = stage1;
      assign rvalid = rd_v1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_init.sv
// Directed bench for ram_sdp_init: two instances (latency 1 / read-first and
// latency 2 / write-first) share stimulus and are checked against an array model.
module tb_ram_sdp_init;

  localparam int          AW    = 4;
  localparam int          DW    = 8;
  localparam int          DEPTH = 16;
  localparam logic [7:0]  INIT  = 8'h3C;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear_req = 1'b0;
  logic          ena = 1'b0;
  logic          wea = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dia = '0;
  logic          enb = 1'b0;
  logic [AW-1:0] addrb = '0;

  logic          busyA, rvA, busyB, rvB;
  logic [DW-1:0] dobA, dobB;

  ram_sdp_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0), .INIT_VAL(INIT)) dutA (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busyA),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dobA), .rvalid(rvA)
  );

  ram_sdp_init #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(1), .INIT_VAL(INIT)) dutB (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busyB),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dobB), .rvalid(rvB)
  );

  always #5 clk = ~clk;

  // Reference model: plain array, clear countdown and per-instance output pipes.
  logic [7:0] mmem [DEPTH];
  bit         mclr;
  int         mcnt;
  logic [7:0] eDobA, eDobB, s1B;
  bit         eRvA, eRvB, v1B;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelUpdate();
    logic [7:0] rdA, rdB;
    bit rd;
    rdA = '0;
    rdB = '0;
    if (rst) begin
      mclr = 1; mcnt = 0;
      eDobA = '0; eRvA = 0;
      eDobB = '0; eRvB = 0; v1B = 0; s1B = '0;
    end else begin
      eRvB = v1B;
      if (v1B) eDobB = s1B;
      rd = enb && !mclr;
      if (rd) begin
        rdA = mmem[addrb];
        rdB = (ena && wea && addra == addrb) ? dia : mmem[addrb];
        eDobA = rdA;
        eRvA = 1;
      end else begin
        eRvA = 0;
      end
      v1B = rd;
      if (rd) s1B = rdB;
      if (mclr) begin
        mmem[mcnt] = INIT;
        mcnt++;
        if (mcnt == DEPTH) mclr = 0;
      end else begin
        if (ena && wea) mmem[addra] = dia;
        if (clear_req) begin mclr = 1; mcnt = 0; end
      end
    end
  endtask

  task automatic checkOutput();
    check("busyA", busyA, mclr);
    check("busyB", busyB, mclr);
    check("rvalidA", rvA, eRvA);
    check("rvalidB", rvB, eRvB);
    check("dobA", dobA, eDobA);
    check("dobB", dobB, eDobB);
  endtask

  task automatic applyStimulus(input bit r, input bit cr, input bit ea, input bit wa,
                               input logic [AW-1:0] aa, input logic [DW-1:0] d,
                               input bit eb, input logic [AW-1:0] ab);
    rst = r; clear_req = cr; ena = ea; wea = wa; addra = aa; dia = d; enb = eb; addrb = ab;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, '0, '0, 0, '0);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busyA && n < 40) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mmem[i] = 'x;

    // Reset, then the power-on sweep
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0);
    check("rst_busy", busyA, 1);
    check("rst_dob", dobA, 0);
    check("rst_rvalid", rvA, 0);
    countBusy(n);
    check("reset_sweep_len", n, 16);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 0, '0, '0, 1, AW'(i));
      check("init_read_lit", dobA, INIT);
    end
    idle();

    // Write then read, both latencies
    applyStimulus(0, 0, 1, 1, 4'd3, 8'hA5, 0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 4'd3);
    check("wr_rd_lat1", dobA, 8'hA5);
    check("wr_rd_lat1_rv", rvA, 1);
    idle();
    check("wr_rd_lat2", dobB, 8'hA5);
    check("wr_rd_lat2_rv", rvB, 1);
    check("hold_lat1", dobA, 8'hA5);

    // Same-address collision
    applyStimulus(0, 0, 1, 1, 4'd7, 8'h11, 0, '0);
    applyStimulus(0, 0, 1, 1, 4'd7, 8'h22, 1, 4'd7);
    check("coll_read_first", dobA, 8'h11);
    idle();
    check("coll_write_first", dobB, 8'h22);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 4'd7);
    check("coll_after", dobA, 8'h22);
    idle();

    // Fill with FF, then clear on request with blocked accesses mid-sweep
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, 1, AW'(i), 8'hFF, 0, '0);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 4'd9);
    check("fill_ff", dobA, 8'hFF);
    applyStimulus(0, 1, 0, 0, '0, '0, 0, '0);
    n = 0;
    while (busyA && n < 40) begin
      applyStimulus(0, n == 5, n == 2, n == 2, 4'd2, 8'h5A, n == 4, 4'd0);
      if (n == 4) begin
        check("clear_rd_blocked_rv", rvA, 0);
        check("clear_rd_blocked_dob", dobA, 8'hFF);
      end
      n++;
    end
    check("req_sweep_len", n, 16);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, '0, '0, 1, AW'(i));
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 4'd2);
    check("blocked_write_dropped", dobA, INIT);
    idle();

    // Reset in the middle of a sweep restarts it
    applyStimulus(0, 0, 1, 1, 4'd4, 8'h77, 0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 8; i++) idle();
    check("mid_busy", busyA, 1);
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0);
    countBusy(n);
    check("restart_sweep_len", n, 16);
    applyStimulus(0, 0, 0, 0, '0, '0, 1, 4'd4);
    check("restart_cleared", dobA, INIT);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
